// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - in-order writeback FIFO feeding the register file write port
//
// Purpose: buffers writeback results from execute/memory stages and drains one
// entry per granted cycle into the register file write port. Writes to register
// 0 are consumed without being stored. Optional forwarding lookup is enabled by
// defining the macro FORWARD_EN.
//
// Ports:
//   CLK, RST                  clock (rising edge), asynchronous active-high reset
//   push_valid/ready/sel/dat  writeback request from the pipeline
//   flush                     synchronous discard of all queued entries
//   rf_grant                  register file write port available this cycle
//   rf_WEN/rf_wsel/rf_wdat    register file write port (combinational from head)
//   count/empty/full          occupancy status
//   lk_sel/lk_hit/lk_dat      forwarding lookup (FORWARD_EN only, else constant 0)
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [AW-1:0]              push_sel,
   input  logic [DW-1:0]              push_dat,
   input  logic                       flush,
   input  logic                       rf_grant,
   output logic                       rf_WEN,
   output logic [AW-1:0]              rf_wsel,
   output logic [DW-1:0]              rf_wdat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   input  logic [AW-1:0]              lk_sel,
   output logic                       lk_hit,
   output logic [DW-1:0]              lk_dat
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] sel_mem [DEPTH];
   logic [DW-1:0] dat_mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          accept;
   logic          enq;
   logic          pop;

   assign empty      = (count == '0);
   assign full       = (count == FULL_CNT);
   assign push_ready = !full || rf_grant;
   assign accept     = push_valid && push_ready;
   // register 0 is hardwired zero: accept the request but never store it
   assign enq        = accept && (push_sel != '0);
   assign rf_WEN     = !empty && rf_grant;
   assign pop        = rf_WEN;
   assign rf_wsel    = empty ? '0 : sel_mem[head];
   assign rf_wdat    = empty ? '0 : dat_mem[head];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         // the head write may still issue this cycle; the queue is emptied regardless
         head  <= tail;
         count <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         if (enq && !pop)
            count <= count + 1'b1;
         else if (!enq && pop)
            count <= count - 1'b1;
      end
   end

   // storage carries no reset: entries are only visible through count
   always_ff @(posedge CLK) begin
      if (enq && !flush) begin
         sel_mem[tail] <= push_sel;
         dat_mem[tail] <= push_dat;
      end
   end

`ifdef FORWARD_EN
   // scan oldest to youngest so the youngest match wins
   always_comb begin
      logic [PW-1:0] idx;
      idx    = '0;
      lk_hit = 1'b0;
      lk_dat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (lk_sel != '0) && (sel_mem[idx] == lk_sel)) begin
            lk_hit = 1'b1;
            lk_dat = dat_mem[idx];
         end
      end
   end
`else
   logic unused_lk_sel;
   assign unused_lk_sel = ^lk_sel;
   assign lk_hit        = 1'b0;
   assign lk_dat        = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb/tb_rf_writeback_queue.sv - self-checking bench for rf_writeback_queue
module tb_rf_writeback_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          CLK;
   logic          RST;
   logic          push_valid;
   logic          push_ready;
   logic [AW-1:0] push_sel;
   logic [DW-1:0] push_dat;
   logic          flush;
   logic          rf_grant;
   logic          rf_WEN;
   logic [AW-1:0] rf_wsel;
   logic [DW-1:0] rf_wdat;
   logic [2:0]    count;
   logic          empty;
   logic          full;
   logic [AW-1:0] lk_sel;
   logic          lk_hit;
   logic [DW-1:0] lk_dat;

   rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .RST(RST),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_sel(push_sel), .push_dat(push_dat),
      .flush(flush), .rf_grant(rf_grant),
      .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
      .count(count), .empty(empty), .full(full),
      .lk_sel(lk_sel), .lk_hit(lk_hit), .lk_dat(lk_dat)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [AW-1:0] sel;
      logic [DW-1:0] dat;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference view of the queue computed directly from the model contents
   task automatic check_outputs();
      int            n;
      logic          e_hit;
      logic [DW-1:0] e_dat;
      n     = q.size();
      e_hit = 1'b0;
      e_dat = '0;
`ifdef FORWARD_EN
      for (int i = n - 1; i >= 0; i--) begin
         if (lk_sel != 0 && q[i].sel == lk_sel) begin
            e_hit = 1'b1;
            e_dat = q[i].dat;
            break;
         end
      end
`endif
      chk("count",      32'(count),      32'(n));
      chk("empty",      32'(empty),      32'(n == 0));
      chk("full",       32'(full),       32'(n == DEPTH));
      chk("push_ready", 32'(push_ready), 32'((n < DEPTH) || rf_grant));
      chk("rf_WEN",     32'(rf_WEN),     32'((n != 0) && rf_grant));
      chk("rf_wsel",    32'(rf_wsel),    (n != 0) ? 32'(q[0].sel) : 32'd0);
      chk("rf_wdat",    rf_wdat,         (n != 0) ? q[0].dat : 32'd0);
      chk("lk_hit",     32'(lk_hit),     32'(e_hit));
      chk("lk_dat",     lk_dat,          e_dat);
   endtask

   task automatic sample();
      @(negedge CLK);
      check_outputs();
   endtask

   task automatic tick();
      bit wen;
      bit acc;
      @(posedge CLK);
      wen = (q.size() != 0) && rf_grant;
      acc = push_valid && ((q.size() < DEPTH) || rf_grant);
      if (RST || flush) begin
         q.delete();
      end else begin
         if (wen) void'(q.pop_front());
         if (acc && push_sel != 0) q.push_back('{sel: push_sel, dat: push_dat});
      end
      #1;
   endtask

   task automatic push_step(input logic [AW-1:0] s, input logic [DW-1:0] d);
      push_valid = 1'b1;
      push_sel   = s;
      push_dat   = d;
      sample();
      tick();
      push_valid = 1'b0;
   endtask

   int exp_order[5] = '{1, 2, 3, 4, 6};
   int got_order[5];

   initial begin
      RST        = 1'b1;
      push_valid = 1'b0;
      push_sel   = '0;
      push_dat   = '0;
      flush      = 1'b0;
      rf_grant   = 1'b1;
      lk_sel     = 5'd7;

      // reset state, with grant high to show no write issues
      sample();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_wen",   32'(rf_WEN), 32'd0);
      tick();
      RST = 1'b0;
      sample();
      tick();

      // basic drain
      push_step(5'd5, 32'hA5A5_0001);
      sample();
      chk("drain_wen",  32'(rf_WEN),  32'd1);
      chk("drain_wsel", 32'(rf_wsel), 32'd5);
      chk("drain_wdat", rf_wdat,      32'hA5A5_0001);
      tick();
      sample();
      chk("drain_empty", 32'(empty), 32'd1);
      tick();

      // backpressure and full with same-cycle pop+push
      rf_grant = 1'b0;
      for (int i = 1; i <= 4; i++) push_step(AW'(i), 32'h100 + 32'(i));
      sample();
      chk("full_flag",  32'(full),       32'd1);
      chk("full_ready", 32'(push_ready), 32'd0);
      tick();
      rf_grant   = 1'b1;
      push_valid = 1'b1;
      push_sel   = 5'd6;
      push_dat   = 32'h106;
      sample();
      chk("full_grant_ready", 32'(push_ready), 32'd1);
      got_order[0] = int'(rf_wsel);
      tick();
      push_valid = 1'b0;
      sample();
      chk("full_count_held", 32'(count), 32'd4);
      for (int i = 1; i < 5; i++) begin
         if (i > 1) sample();
         got_order[i] = rf_WEN ? int'(rf_wsel) : -1;
         tick();
      end
      for (int i = 0; i < 5; i++) chk("drain_order", 32'(got_order[i]), 32'(exp_order[i]));

      // register 0 is consumed but never stored
      rf_grant   = 1'b0;
      push_valid = 1'b1;
      push_sel   = 5'd0;
      push_dat   = 32'hFFFF_FFFF;
      sample();
      chk("r0_ready", 32'(push_ready), 32'd1);
      tick();
      push_valid = 1'b0;
      rf_grant   = 1'b1;
      sample();
      chk("r0_count", 32'(count),  32'd0);
      chk("r0_wen",   32'(rf_WEN), 32'd0);
      tick();

      // reset while draining with three entries held
      rf_grant = 1'b0;
      for (int i = 0; i < 4; i++) push_step(AW'(10 + i), 32'h200 + 32'(i));
      rf_grant = 1'b1;
      sample();
      tick();
      RST = 1'b1;
      #1;
      q.delete();
      sample();
      chk("mid_rst_count", 32'(count),  32'd0);
      chk("mid_rst_empty", 32'(empty),  32'd1);
      chk("mid_rst_wen",   32'(rf_WEN), 32'd0);
      chk("mid_rst_hit",   32'(lk_hit), 32'd0);
      tick();
      RST = 1'b0;

      // flush overrides a same-cycle push, then wrap-around traffic
      rf_grant = 1'b0;
      for (int i = 0; i < 3; i++) push_step(AW'(20 + i), 32'h300 + 32'(i));
      flush      = 1'b1;
      push_valid = 1'b1;
      push_sel   = 5'd9;
      push_dat   = 32'hDEAD_0009;
      sample();
      tick();
      flush      = 1'b0;
      push_valid = 1'b0;
      sample();
      chk("flush_count", 32'(count), 32'd0);
      tick();
      rf_grant = 1'b1;
      for (int i = 0; i < 6; i++) push_step(AW'(1 + i), 32'h400 + 32'(i));
      for (int i = 0; i < 2; i++) begin sample(); tick(); end

      // forwarding lookup
      rf_grant = 1'b0;
      push_step(5'd7, 32'h11);
      push_step(5'd9, 32'h22);
      push_step(5'd7, 32'h33);
      lk_sel = 5'd7;
      sample();
`ifdef FORWARD_EN
      chk("fwd_hit7", 32'(lk_hit), 32'd1);
      chk("fwd_dat7", lk_dat,      32'h33);
`else
      chk("fwd_hit7", 32'(lk_hit), 32'd0);
      chk("fwd_dat7", lk_dat,      32'd0);
`endif
      tick();
      lk_sel = 5'd8;
      sample();
      chk("fwd_hit8", 32'(lk_hit), 32'd0);
      tick();
      rf_grant = 1'b1;
      for (int i = 0; i < 4; i++) begin sample(); tick(); end

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         push_valid = ($urandom_range(0, 99) < 60);
         push_sel   = AW'($urandom_range(0, 7));
         push_dat   = $urandom;
         rf_grant   = ($urandom_range(0, 99) < 55);
         flush      = ($urandom_range(0, 99) < 4);
         lk_sel     = AW'($urandom_range(0, 7));
         sample();
         tick();
      end
      push_valid = 1'b0;
      flush      = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
